// File: rtl/adder_accum_pkg.sv
// Shared types and constants for the byte-serial accumulator controller.
package adder_accum_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder; overflow is the carry out of the top bit.
module adder_8bit
  import adder_accum_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in,
  output logic [BYTE_W-1:0] sum,
  output logic              overflow
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    overflow = c[BYTE_W];
  end

endmodule

// File: rtl/adder_accum_ctrl.sv
// Byte-serial accumulator: one shared 8-bit adder walks the accumulator a byte
// per clock, with the inter-byte carry held in a register.
module adder_accum_ctrl
  import adder_accum_pkg::*;
#(
  parameter int NUM_BYTES = 2
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [BYTE_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] sum_out,
  output logic                        overflow,
  output logic                        busy,
  output logic                        done
);

  localparam int ACC_W = BYTE_W * NUM_BYTES;
  localparam int IDX_W = (clog2(NUM_BYTES) > 0) ? clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   work_q, work_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [BYTE_W-1:0]  opnd_q, opnd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BYTE_W-1:0]  add_a, add_b, add_sum;
  logic               add_cout;

  // Operand enters only on byte 0; higher bytes just absorb the carry.
  always_comb begin
    add_a = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) add_a = work_q[i*BYTE_W +: BYTE_W];
    end
    add_b = (idx_q == '0) ? opnd_q : '0;
  end

  adder_8bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .carry_in (carry_q),
    .sum      (add_sum),
    .overflow (add_cout)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    sum_d   = sum_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      work_d  = '0;
      sum_d   = '0;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opnd_d  = in_data;
            idx_d   = '0;
            carry_d = 1'b0;
            state_d = ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) work_d[i*BYTE_W +: BYTE_W] = add_sum;
          end
          carry_d = add_cout;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = COMMIT;
        end
        COMMIT: begin
          sum_d   = work_q;
          ovf_d   = ovf_q | carry_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      sum_q   <= '0;
      opnd_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      opnd_q  <= opnd_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sum_out  = sum_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Bench for adder_accum_ctrl: NUM_BYTES=1, 2 and 4 instances side by side,
// checked against constant vectors and a modulo-arithmetic reference model.
module tb_adder_accum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  cl, iv, ir, ov, bz, dn;
  logic [7:0]  id [3];
  logic [7:0]  s0;
  logic [15:0] s1;
  logic [31:0] s2;

  int     n_chk = 0;
  int     n_fail = 0;
  longint mtot [3];
  bit     mov  [3];

  typedef struct {
    logic [7:0] d;
    longint     sum;
    bit         ovf;
  } vec_t;

  adder_accum_ctrl #(.NUM_BYTES(1)) u_n1 (
    .clk(clk), .rst(rst), .clear(cl[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(ir[0]), .sum_out(s0), .overflow(ov[0]), .busy(bz[0]), .done(dn[0]));

  adder_accum_ctrl #(.NUM_BYTES(2)) u_n2 (
    .clk(clk), .rst(rst), .clear(cl[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(ir[1]), .sum_out(s1), .overflow(ov[1]), .busy(bz[1]), .done(dn[1]));

  adder_accum_ctrl #(.NUM_BYTES(4)) u_n4 (
    .clk(clk), .rst(rst), .clear(cl[2]), .in_valid(iv[2]), .in_data(id[2]),
    .in_ready(ir[2]), .sum_out(s2), .overflow(ov[2]), .busy(bz[2]), .done(dn[2]));

  function automatic int nb(input int k);
    int r;
    case (k)
      0:       r = 1;
      1:       r = 2;
      default: r = 4;
    endcase
    return r;
  endfunction

  function automatic longint get_sum(input int k);
    longint r;
    case (k)
      0:       r = longint'(s0);
      1:       r = longint'(s1);
      default: r = longint'(s2);
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int k);
    cl[k] = 1'b1;
    tick();
    cl[k] = 1'b0;
    mtot[k] = 0;
    mov[k]  = 1'b0;
  endtask

  // One full handshake on instance k, checked against the reference model.
  task automatic op(input int k, input logic [7:0] d);
    int     g;
    int     lat;
    longint m;
    longint t;
    g = 0;
    while (ir[k] !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    chk("ready_before_accept", longint'(ir[k]), 1);
    iv[k] = 1'b1;
    id[k] = d;
    tick();
    iv[k] = 1'b0;
    m = longint'(1) << (8 * nb(k));
    t = mtot[k] + longint'(d);
    if (t >= m) begin
      t = t - m;
      mov[k] = 1'b1;
    end
    mtot[k] = t;
    lat = 0;
    while (dn[k] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", longint'(lat), longint'(nb(k) + 1));
    chk("sum_model", get_sum(k), mtot[k]);
    chk("ovf_model", longint'(ov[k]), longint'(mov[k]));
    tick();
    chk("done_width", longint'(dn[k]), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       tbl [6];
    int         acc, low, bad, cnt;
    logic [7:0] d;

    tbl[0] = '{8'hFF, 64'h00FF, 1'b0};
    tbl[1] = '{8'h01, 64'h0100, 1'b0};
    tbl[2] = '{8'h00, 64'h0100, 1'b0};
    tbl[3] = '{8'h80, 64'h0180, 1'b0};
    tbl[4] = '{8'h80, 64'h0200, 1'b0};
    tbl[5] = '{8'hFF, 64'h02FF, 1'b0};

    rst = 1'b1;
    cl  = '0;
    iv  = '0;
    for (int k = 0; k < 3; k++) begin
      id[k]   = 8'h00;
      mtot[k] = 0;
      mov[k]  = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    chk("rst_sum", get_sum(1), 0);
    chk("rst_ovf", longint'(ov[1]), 0);
    chk("rst_ready", longint'(ir[1]), 1);
    chk("rst_busy", longint'(bz[1]), 0);
    chk("rst_done", longint'(dn[1]), 0);
    chk("rst_sum_n1", get_sum(0), 0);
    chk("rst_sum_n4", get_sum(2), 0);

    for (int i = 0; i < 6; i++) begin
      op(1, tbl[i].d);
      chk("tbl_sum", get_sum(1), tbl[i].sum);
      chk("tbl_ovf", longint'(ov[1]), longint'(tbl[i].ovf));
    end

    clr(1);
    for (int i = 0; i < 257; i++) op(1, 8'hFF);
    chk("wrap_full_sum", get_sum(1), 64'hFFFF);
    chk("wrap_full_ovf", longint'(ov[1]), 0);
    op(1, 8'h01);
    chk("wrap_sum", get_sum(1), 64'h0000);
    chk("wrap_ovf", longint'(ov[1]), 1);
    op(1, 8'h05);
    chk("post_wrap_sum", get_sum(1), 64'h0005);
    chk("post_wrap_ovf_sticky", longint'(ov[1]), 1);

    // Clear lands on the second ADD cycle of an in-flight operand.
    iv[1] = 1'b1;
    id[1] = 8'h80;
    tick();
    iv[1] = 1'b0;
    tick();
    cl[1] = 1'b1;
    tick();
    cl[1] = 1'b0;
    mtot[1] = 0;
    mov[1]  = 1'b0;
    chk("clr_ready", longint'(ir[1]), 1);
    chk("clr_busy", longint'(bz[1]), 0);
    chk("clr_sum", get_sum(1), 0);
    chk("clr_ovf", longint'(ov[1]), 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (dn[1] === 1'b1) cnt++;
      tick();
    end
    chk("clr_no_done", longint'(cnt), 0);
    op(1, 8'h03);
    chk("clr_then_add", get_sum(1), 64'h0003);

    clr(1);
    iv[1] = 1'b1;
    id[1] = 8'h10;
    acc = 0;
    low = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (ir[1] === 1'b1) acc++;
      else low++;
      if (bz[1] === ir[1]) bad++;
      tick();
    end
    iv[1] = 1'b0;
    chk("hs_accepts", longint'(acc), 2);
    chk("hs_ready_low", longint'(low), 6);
    chk("hs_busy_vs_ready", longint'(bad), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("hs_sum", get_sum(1), 64'h0020);
    mtot[1] = 64'h20;

    cl[1] = 1'b1;
    iv[1] = 1'b1;
    id[1] = 8'h40;
    tick();
    cl[1] = 1'b0;
    iv[1] = 1'b0;
    mtot[1] = 0;
    mov[1]  = 1'b0;
    chk("clrv_ready", longint'(ir[1]), 1);
    chk("clrv_busy", longint'(bz[1]), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dn[1] === 1'b1 || bz[1] === 1'b1) cnt++;
      tick();
    end
    chk("clrv_no_accept", longint'(cnt), 0);
    chk("clrv_sum", get_sum(1), 0);

    // Reset in the middle of ADD discards the partial result.
    iv[1] = 1'b1;
    id[1] = 8'h22;
    tick();
    iv[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mtot[k] = 0;
      mov[k]  = 1'b0;
    end
    chk("rst_mid_ready", longint'(ir[1]), 1);
    chk("rst_mid_sum", get_sum(1), 0);
    op(1, 8'h07);
    chk("rst_mid_then_add", get_sum(1), 64'h0007);

    for (int j = 0; j < 3; j++) begin
      int k;
      k = (j == 0) ? 0 : ((j == 1) ? 2 : 1);
      clr(k);
      for (int i = 0; i < 40; i++) begin
        d = 8'($urandom_range(0, 255));
        if ((i % 5) == 0) d = 8'hFF;
        op(k, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
